input_conditioner_bank: RTL and testbench
=========================================

INPUT_CONDITIONER_BANK -- requirements
Module: input_conditioner_bank

Interface
REQ-001 SHALL have parameter N, default 4: number of independent input channels, N >= 1.
REQ-002 SHALL have parameter T, default 4: debounce length in clock cycles, 1 <= T <= 2^CW.
REQ-003 SHALL have parameter CW, default 8: width of each channel's debounce counter.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pin, input, N bits: asynchronous raw inputs, bit i = channel i.
REQ-007 SHALL have port invert, input, N bits: per-channel polarity select, 1 = logically inverted.
REQ-008 SHALL have port conditioned, output, N bits: synchronized, debounced, polarity-corrected level.
REQ-009 SHALL have port rising, output, N bits: one-cycle pulse when conditioned[i] goes 0->1.
REQ-010 SHALL have port falling, output, N bits: one-cycle pulse when conditioned[i] goes 1->0.
REQ-011 SHALL have port any_edge, output, 1 bit: OR of all rising and falling bits, same cycle.

Function
REQ-012 SHALL pass each pin[i] through a two-flop synchronizer, s1 <= pin, s2 <= s1, before any other use.
REQ-013 SHALL form the effective level e[i] = s2[i] XOR invert[i]; invert is used unregistered.
REQ-014 SHALL clear the channel counter whenever e[i] == conditioned[i].
REQ-015 SHALL increment the counter when e[i] != conditioned[i] and counter < T-1.
REQ-016 SHALL, when e[i] != conditioned[i] and counter == T-1, load conditioned[i] <= e[i], clear the counter, and register the matching rising/falling pulse on the same edge.
REQ-017 SHALL drive rising/falling high for exactly one cycle per transition, never both in one cycle on the same channel.
REQ-018 SHALL give latency: a level on pin held stable appears on conditioned at the (T+2)th rising edge, counting the first edge that samples it in s1 as edge 1.
REQ-019 SHALL reject any effective mismatch lasting fewer than T consecutive cycles at s2, with no pulse and no change.
REQ-020 SHALL keep channels fully independent; simultaneous events on several channels all report in the same cycle.
REQ-021 SHALL treat a toggle of invert[i] as an input change subject to the same debounce.

Reset
REQ-022 SHALL, while reset is high at a clock edge, clear s1, s2, all counters, conditioned, rising, falling and any_edge to 0.
REQ-023 SHALL discard any in-progress debounce count on reset; counting restarts from 0 after release.
REQ-024 SHALL produce no edge pulse in the reset cycle or in the first cycle after release.

Configuration
REQ-025 SHALL, with macro INPUTCOND_STICKY_EN defined, add input clear_events (N bits) and outputs rise_seen, fall_seen (N bits each).
REQ-026 SHALL, with the macro, set rise_seen[i]/fall_seen[i] on the edge after rising[i]/falling[i] is high, hold them until clear_events[i] is high, and give set priority if both occur together; reset clears them.
REQ-027 SHALL, without the macro, omit these ports and their logic entirely; all other behaviour is identical.

Verification (N=4, T=4)
REQ-028 SHALL cover: reset, then pin[0] 0->1 held -> conditioned[0]=1 and rising[0]=1 at edge 6, rising[0]=0 at edge 7, any_edge pulses once, other channels stay 0.
REQ-029 SHALL cover: conditioned[1]=0, then pin[1] high for 3 cycles -> no change, no pulse; the same pin[1] high for 4 cycles -> conditioned[1]=1 with one rising pulse.
REQ-030 SHALL cover: pin[2] 0->1 and pin[3] 1->0 on the same edge -> rising[2] and falling[3] in the same cycle, any_edge high for one cycle.
REQ-031 SHALL cover: pin all 0 and invert[0] 0->1 -> conditioned[0]=1 and rising[0]=1 four cycles after e[0] changes.
REQ-032 SHALL cover: reset asserted two edges into a pending transition -> outputs 0; after release a held pin is re-debounced with the full T+2 latency.
REQ-033 SHALL cover (INPUTCOND_STICKY_EN): rising[0] pulse, then clear_events[0] high on the same edge rise_seen[0] would set -> rise_seen[0]=1; a later clear alone -> 0.

Source files
------------

// File: rtl/input_conditioner_bank.sv
// input_conditioner_bank: per-channel 2-flop sync, polarity select, debounce and edge pulses.
// Optional sticky event flags when INPUTCOND_STICKY_EN is defined.
module input_conditioner_bank #(
  parameter int N  = 4,
  parameter int T  = 4,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pin,
  input  logic [N-1:0] invert,
`ifdef INPUTCOND_STICKY_EN
  input  logic [N-1:0] clear_events,
  output logic [N-1:0] rise_seen,
  output logic [N-1:0] fall_seen,
`endif
  output logic [N-1:0] conditioned,
  output logic [N-1:0] rising,
  output logic [N-1:0] falling,
  output logic         any_edge
);
  localparam logic [CW-1:0] LAST = CW'(T - 1);
  logic [N-1:0] s1, s2, e, fire;
  logic [CW-1:0] cnt [N];
  assign e = s2 ^ invert;
  assign any_edge = |(rising | falling);
  // fire only when the mismatch has persisted T consecutive cycles
  always_comb begin
    fire = '0;
    for (int i = 0; i < N; i++) fire[i] = (e[i] != conditioned[i]) && (cnt[i] == LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      conditioned <= '0;
      rising      <= '0;
      falling     <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1          <= pin;
      s2          <= s1;
      conditioned <= conditioned ^ fire;
      rising      <= fire & e;
      falling     <= fire & ~e;
      for (int i = 0; i < N; i++)
        cnt[i] <= (e[i] == conditioned[i] || fire[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
`ifdef INPUTCOND_STICKY_EN
  // set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_seen <= '0;
      fall_seen <= '0;
    end else begin
      rise_seen <= rising | (rise_seen & ~clear_events);
      fall_seen <= falling | (fall_seen & ~clear_events);
    end
  end
`endif
endmodule

// File: tb/tb_input_conditioner_bank.sv
// tb_input_conditioner_bank: table-driven check of input_conditioner_bank (N=4, T=4)
module tb_input_conditioner_bank;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] pin = '0, invert = '0, conditioned, rising, falling;
  logic any_edge;
`ifdef INPUTCOND_STICKY_EN
  logic [3:0] clear_events = '0, rise_seen, fall_seen;
`endif
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic r;
    logic [3:0] p, i, c, ri, f;
    logic a;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  input_conditioner_bank #(.N(4), .T(4), .CW(8)) dut (
    .clk(clk),
    .reset(reset),
    .pin(pin),
    .invert(invert),
`ifdef INPUTCOND_STICKY_EN
    .clear_events(clear_events),
    .rise_seen(rise_seen),
    .fall_seen(fall_seen),
`endif
    .conditioned(conditioned),
    .rising(rising),
    .falling(falling),
    .any_edge(any_edge)
  );

  task automatic add(input logic r, input logic [3:0] p, input logic [3:0] i, input logic [3:0] c,
                     input logic [3:0] ri, input logic [3:0] f, input logic a, input int n);
    vec_t x;
    x.r = r; x.p = p; x.i = i; x.c = c; x.ri = ri; x.f = f; x.a = a;
    repeat (n) tbl.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic [3:0] i);
    @(negedge clk);
    reset = r; pin = p; invert = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    // reset, then pin[0] rises: visible at 6th edge after release
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 5);
    add(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1, 1);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 1);
    // pin[1] glitch of 3 cycles is rejected
    add(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 0, 3);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 4);
    // pin[1] high exactly 4 cycles is accepted, then falls back
    add(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 0, 4);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 1);
    add(0, 4'h1, 4'h0, 4'h3, 4'h2, 4'h0, 1, 1);
    add(0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h0, 0, 3);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h2, 1, 1);
    add(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 1);
    // bring ch3 up, then ch2 up and ch3 down together
    add(0, 4'h9, 4'h0, 4'h1, 4'h0, 4'h0, 0, 5);
    add(0, 4'h9, 4'h0, 4'h9, 4'h8, 4'h0, 1, 1);
    add(0, 4'h9, 4'h0, 4'h9, 4'h0, 4'h0, 0, 1);
    add(0, 4'h5, 4'h0, 4'h9, 4'h0, 4'h0, 0, 5);
    add(0, 4'h5, 4'h0, 4'h5, 4'h4, 4'h8, 1, 1);
    add(0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 0, 1);
    // all low, then invert[0] toggles
    add(0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 0, 5);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 1, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1);
    add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 3);
    add(0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1, 1);
    add(0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 1);
    add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 3);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1, 1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].p, tbl[k].i);
      check("row", k, {conditioned, rising, falling, 3'b000, any_edge},
            {tbl[k].c, tbl[k].ri, tbl[k].f, 3'b000, tbl[k].a});
    end

    // reset in the middle of a pending transition, then full re-debounce
    step(1, 4'h0, 4'h0);
    step(0, 4'h2, 4'h0);
    step(0, 4'h2, 4'h0);
    step(0, 4'h2, 4'h0);
    step(1, 4'h2, 4'h0);
    check("rst_mid", 0, {conditioned, rising, falling, 3'b000, any_edge}, 16'h0);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 4'h2, 4'h0);
      if (first == 0 && conditioned[1]) begin
        first = k;
        check("rst_rise", k, {12'h0, rising}, 16'h2);
      end
    end
    check("rst_latency", 0, 16'(first), 16'd6);

`ifdef INPUTCOND_STICKY_EN
    step(1, 4'h0, 4'h0);
    for (int k = 1; k <= 6; k++) step(0, 4'h1, 4'h0);
    check("stk_rise", 0, {12'h0, rising}, 16'h1);
    clear_events = 4'h1;
    step(0, 4'h1, 4'h0);
    check("stk_setpri", 0, {12'h0, rise_seen}, 16'h1);
    clear_events = 4'h0;
    step(0, 4'h1, 4'h0);
    check("stk_hold", 0, {12'h0, rise_seen}, 16'h1);
    clear_events = 4'h1;
    step(0, 4'h1, 4'h0);
    check("stk_clear", 0, {12'h0, rise_seen}, 16'h0);
    clear_events = 4'h0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
